// File: rtl/mem_access_unit.sv
// Single-outstanding data memory access unit: validates a load/store request,
// drives a held memory access until completion or timeout, then returns a response.
module mem_access_unit #(
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [31:0] ADDR_LIMIT = 32'h00010000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  input  logic        MEM_VALID2
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        accept, bad_size, misalign, mem_done, timed_out;

  // ADDR_LIMIT only documents where MMIO begins; no address decoding uses it.
  if (ADDR_LIMIT == 32'd0) begin : g_no_mmio_window
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;
  assign bad_size   = (req_size == 2'd3);
  assign misalign   = ((req_size == 2'd1) & req_addr[0]) |
                      ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
  // Completion beats timeout when both land on the same edge.
  assign mem_done   = (state == ACCESS) & MEM_VALID2;
  assign timed_out  = (state == ACCESS) & ~MEM_VALID2 & (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bad_size | misalign) ? RESP : ACCESS;
      ACCESS:  if (mem_done | timed_out) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      MEM_RDEN2  <= 1'b0;
      MEM_WE2    <= 1'b0;
      MEM_ADDR2  <= '0;
      MEM_DIN2   <= '0;
      MEM_SIZE   <= '0;
      MEM_SIGN   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            resp_rdata <= '0;
            if (bad_size) begin
              resp_err <= ERR_SIZE;
            end else if (misalign) begin
              resp_err <= ERR_MISALIGN;
            end else begin
              resp_err  <= ERR_OK;
              MEM_RDEN2 <= ~req_write;
              MEM_WE2   <= req_write;
              MEM_ADDR2 <= req_addr;
              MEM_DIN2  <= req_wdata;
              MEM_SIZE  <= req_size;
              MEM_SIGN  <= req_unsigned;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          if (mem_done | timed_out) begin
            resp_err   <= mem_done ? ERR_OK : ERR_TIMEOUT;
            // MEM_RDEN2 is still the held load flag on this edge.
            resp_rdata <= (mem_done & MEM_RDEN2) ? MEM_DOUT2 : 32'd0;
            MEM_RDEN2  <= 1'b0;
            MEM_WE2    <= 1'b0;
            MEM_ADDR2  <= '0;
            MEM_DIN2   <= '0;
            MEM_SIZE   <= '0;
            MEM_SIGN   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a per-transaction outcome model.
module tb_mem_access_unit;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN, MEM_VALID2 = 1'b0;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2 = '0;
  logic [1:0]  MEM_SIZE;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT(TO), .ADDR_LIMIT(32'h00010000)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .MEM_VALID2(MEM_VALID2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic scramble_req();
    req_write    = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask

  // dly: index of the enable cycle in which memory completes (> TO means never).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int dly,
                         input logic [31:0] dout, input int hold);
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    int          exp_en, en_cnt, cyc;
    bit          legal, fields_ok, hold_ok;

    if (size == 2'd3)                                              exp_err = 2'd3;
    else if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) exp_err = 2'd1;
    else if (dly <= TO)                                            exp_err = 2'd0;
    else                                                           exp_err = 2'd2;
    legal     = (exp_err == 2'd0) || (exp_err == 2'd2);
    exp_en    = !legal ? 0 : (dly < TO ? dly : TO);
    exp_rdata = (exp_err == 2'd0 && !wr) ? dout : 32'd0;

    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    MEM_VALID2 = 1'($urandom);          // ignored while idle
    MEM_DOUT2  = $urandom;
    tick();
    req_valid = 1'($urandom);
    scramble_req();

    en_cnt = 0; cyc = 0; fields_ok = 1;
    while (!resp_valid && cyc < TO + 10) begin
      if (MEM_RDEN2 || MEM_WE2) begin
        en_cnt++;
        if (MEM_RDEN2 !== !wr || MEM_WE2 !== wr || MEM_ADDR2 !== addr ||
            MEM_SIZE !== size || MEM_SIGN !== uns || (wr && MEM_DIN2 !== wdata))
          fields_ok = 0;
      end
      MEM_VALID2 = legal && (en_cnt == dly);
      MEM_DOUT2  = (en_cnt == dly) ? dout : $urandom;
      tick();
      cyc++;
      req_valid = 1'($urandom);
      scramble_req();
    end
    MEM_VALID2 = 1'b0;

    chk("latency", cyc, exp_en);
    chk("en_cycles", en_cnt, exp_en);
    chk("mem_fields", fields_ok, 1);
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, exp_err);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("en_off", {MEM_RDEN2, MEM_WE2}, 0);

    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      MEM_VALID2 = 1'($urandom);        // ignored while responding
      MEM_DOUT2  = $urandom;
      tick();
      req_valid = 1'($urandom);
      scramble_req();
      if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rdata ||
          req_ready !== 1'b0 || MEM_RDEN2 || MEM_WE2)
        hold_ok = 0;
    end
    chk("resp_hold", hold_ok, 1);

    MEM_VALID2 = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("rst_mem", {MEM_RDEN2, MEM_WE2, MEM_SIZE, MEM_SIGN}, 0);
    chk("rst_addr", MEM_ADDR2, 0);
    chk("rst_din", MEM_DIN2, 0);
    RST = 1'b0;
    tick();

    run_txn(1'b0, 32'h100, 32'h5555_AAAA, 2'd2, 1'b0, 12, 32'hDEADBEEF, 2);
    run_txn(1'b1, 32'h202, 32'h0000_1234, 2'd1, 1'b0, 4, 32'hCAFE_F00D, 1);
    run_txn(1'b0, 32'h103, 32'h0, 2'd2, 1'b0, 3, 32'h1111_1111, 0);
    run_txn(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 3, 32'h2222_2222, 1);
    run_txn(1'b0, 32'h041, 32'h0, 2'd1, 1'b1, 2, 32'h3333_3333, 0);
    run_txn(1'b0, 32'h040, 32'h0, 2'd2, 1'b0, TO + 5, 32'h4444_4444, 0);
    run_txn(1'b1, 32'h044, 32'h9876_5432, 2'd2, 1'b0, TO + 1, 32'h0, 0);
    run_txn(1'b0, 32'h048, 32'h0, 2'd2, 1'b1, TO, 32'h5A5A_A5A5, 0);
    run_txn(1'b0, 32'h04B, 32'h0, 2'd0, 1'b1, 1, 32'h0000_00FF, 5);

    // Reset in the middle of a load; late completion must not produce a response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_size = 2'd2;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_en", MEM_RDEN2, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_en", {MEM_RDEN2, MEM_WE2}, 0);
    chk("mid_rst_addr", MEM_ADDR2, 0);
    chk("mid_rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("mid_rst_ready", req_ready, 1);
    tick();
    MEM_VALID2 = 1'b1; MEM_DOUT2 = 32'hBAD0_BAD0;
    tick();
    MEM_VALID2 = 1'b0;
    tick();
    chk("late_valid", {resp_valid, resp_rdata}, 0);
    chk("late_ready", req_ready, 1);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom),
              $urandom_range(1, TO + 3), $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, max cycles in ACCESS before abort (legal 2..65535).
REQ-002 SHALL have parameter ADDR_LIMIT, default 32'h00010000, informational only; the unit SHALL NOT treat MMIO addresses specially.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline requests a data access.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, unshifted.
REQ-010 req_size  input  2  0 byte, 1 half, 2 word.
REQ-011 req_unsigned  input  1  1 = zero-extend load.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  pipeline consumes response.
REQ-014 resp_rdata  output  32  load data, 0 for stores and errors.
REQ-015 resp_err  output  2  0 ok, 1 misaligned, 2 timeout, 3 illegal size.
REQ-016 MEM_RDEN2, MEM_WE2  output  1 each  memory read/write enables.
REQ-017 MEM_ADDR2, MEM_DIN2  output  32 each  memory address, store data.
REQ-018 MEM_SIZE  output  2;  MEM_SIGN  output  1 (1 = unsigned).
REQ-019 MEM_DOUT2  input  32;  MEM_VALID2  input  1  memory data / completion.

Function
REQ-020 States SHALL be IDLE, ACCESS, RESP; req_ready SHALL equal (state==IDLE).
REQ-021 Handshake: request accepted on edge where req_valid & req_ready; all req_* fields registered at that edge.
REQ-022 Accepted request SHALL be checked at acceptance: size 3 -> err 3; half with addr[0]=1 or word with addr[1:0]!=0 -> err 1; error requests go IDLE->RESP without ever asserting MEM_RDEN2/MEM_WE2.
REQ-023 Legal request SHALL go IDLE->ACCESS; from the next cycle MEM_RDEN2 (load) or MEM_WE2 (store) SHALL be 1, exactly one of them.
REQ-024 All MEM_* outputs SHALL be registered and held constant for the whole ACCESS stay.
REQ-025 Edge in ACCESS with MEM_VALID2=1: capture MEM_DOUT2 (loads) into resp_rdata, err 0, deassert enables, go RESP; enables low the cycle after.
REQ-026 Timeout counter (16 bit) SHALL clear on entry to ACCESS and increment each ACCESS cycle; when it equals TIMEOUT-1 and MEM_VALID2=0: err 2, rdata 0, enables deasserted, go RESP.
REQ-027 MEM_VALID2 and timeout on same edge: MEM_VALID2 wins (err 0).
REQ-028 MEM_VALID2 in IDLE or RESP SHALL be ignored.
REQ-029 RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready=1, then go IDLE at that edge.
REQ-030 Minimum legal access: accept edge N, enables high N+1, VALID2 at edge N+k, resp_valid high from N+k+1; next accept no earlier than one cycle after response consumed.
REQ-031 Store response: resp_rdata=0; MEM_DIN2=req_wdata unmodified.
REQ-032 One outstanding request only; req_* changes while not ready SHALL have no effect.

Reset
REQ-033 RST at edge SHALL force: state IDLE, req_ready=1 next cycle, resp_valid=0, resp_rdata=0, resp_err=0, all MEM_* outputs 0, counter 0.
REQ-034 RST mid-ACCESS SHALL drop enables at that edge; a later MEM_VALID2 SHALL be ignored and produce no response.
REQ-035 RST has priority over every other event in the same cycle.

Verification
REQ-036 Load word addr 0x100, memory returns 0xDEADBEEF after 12 cycles -> MEM_RDEN2 high 12 cycles, resp_valid with rdata 0xDEADBEEF, err 0.
REQ-037 Store half addr 0x202 data 0x1234 -> MEM_WE2=1, MEM_SIZE=1, MEM_DIN2=0x00001234 until VALID2; resp err 0, rdata 0.
REQ-038 Load word addr 0x103 -> no enable ever asserted, resp err 1 the cycle after accept; size 3 -> err 3.
REQ-039 TIMEOUT=8, memory never valid -> enables high exactly 8 cycles, resp err 2; VALID2 on 8th cycle instead -> err 0.
REQ-040 RST asserted 3 cycles into load, VALID2 pulsed 2 cycles later -> outputs zero, no resp_valid; resp_ready held low 5 cycles in RESP -> response held stable, req_ready 0.
